// File: rtl/sramlike_mem_responder.sv
// Responder end of the sram-like bus: in-order queue of accepted requests answered from a word memory.
// Optional macro SRAMLIKE_RANDOM_STALL_EN adds LFSR-driven address-phase stalls.
module sramlike_mem_responder #(
  parameter int    DEPTH_LOG2  = 10,
  parameter int    LATENCY     = 2,
  parameter int    QUEUE_DEPTH = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int WORDS  = 1 << DEPTH_LOG2;
  localparam int PTR_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int OCC_W  = $clog2(QUEUE_DEPTH + 1);
  localparam int CNT_W  = 4;
  localparam bit BYPASS = (LATENCY == 1);

  typedef struct packed {
    logic [DEPTH_LOG2+1:0] addr;
    logic                  wr;
    logic [1:0]            size;
    logic [31:0]           wdata;
  } entry_t;

  entry_t                  q_entry [QUEUE_DEPTH];
  logic [CNT_W-1:0]        q_cnt   [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0]  q_valid;
  logic [PTR_W-1:0]        head;
  logic [PTR_W-1:0]        tail;
  logic [OCC_W-1:0]        occ;
  logic [31:0]             mem [WORDS];

  entry_t                  in_e;
  entry_t                  resp_e;
  logic                    full;
  logic                    stall;
  logic                    push;
  logic                    q_pop;
  logic                    resp_fire;
  logic [3:0]              be;
  logic                    misaligned;
  logic [DEPTH_LOG2-1:0]   resp_idx;
  logic                    unused_addr;

  assign unused_addr = ^addr[31:DEPTH_LOG2+2];

`ifdef SRAMLIKE_RANDOM_STALL_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lfsr <= 16'hACE1;
    else      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall = (lfsr[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Full blocks acceptance outright, even when the head leaves on the same edge.
  assign full    = (occ == OCC_W'(QUEUE_DEPTH));
  assign addr_ok = rst & req & ~full & ~stall;
  assign in_e    = {addr[DEPTH_LOG2+1:0], wr, size, wdata};
  assign push    = addr_ok & ~BYPASS;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QUEUE_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Head leaves on the edge where its countdown would reach zero; a one-cycle latency skips the queue.
  always_comb begin
    resp_fire = 1'b0;
    resp_e    = q_entry[head];
    if (BYPASS) begin
      resp_fire = addr_ok;
      resp_e    = in_e;
    end else begin
      resp_fire = q_valid[head] && (q_cnt[head] <= CNT_W'(1));
    end
  end

  assign q_pop    = resp_fire & ~BYPASS;
  assign resp_idx = resp_e.addr[DEPTH_LOG2+1:2];

  always_comb begin
    be         = 4'b1111;
    misaligned = 1'b0;
    case (resp_e.size)
      2'd0: be = 4'b0001 << resp_e.addr[1:0];
      2'd1: begin
        be         = resp_e.addr[1] ? 4'b1100 : 4'b0011;
        misaligned = resp_e.addr[0];
      end
      default: misaligned = (resp_e.addr[1:0] != 2'b00);
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head    <= '0;
      tail    <= '0;
      occ     <= '0;
      q_valid <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) q_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (q_valid[i] && (q_cnt[i] != '0)) q_cnt[i] <= q_cnt[i] - 1'b1;
      end
      if (q_pop) begin
        q_valid[head] <= 1'b0;
        head          <= ptr_next(head);
      end
      if (push) begin
        q_valid[tail] <= 1'b1;
        q_cnt[tail]   <= CNT_W'(LATENCY - 1);
        tail          <= ptr_next(tail);
      end
      case ({push, q_pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) q_entry[tail] <= in_e;
  end

  // Writes commit when the entry retires, so later reads in the queue observe them.
  always_ff @(posedge clk) begin
    if (resp_fire && resp_e.wr && !misaligned) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[resp_idx][8*b +: 8] <= resp_e.wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_ok <= 1'b0;
      rdata   <= '0;
    end else begin
      data_ok <= resp_fire;
      if (resp_fire) rdata <= resp_e.wr ? 32'h0 : mem[resp_idx];
    end
  end

endmodule

// File: tb/tb_sramlike_mem_responder.sv
// Bench for sramlike_mem_responder: two instances (short and long latency) against a timestamp queue model.
// Build with SRAMLIKE_RANDOM_STALL_EN to exercise the LFSR-driven address-phase stalls.
module tb_sramlike_mem_responder;

  localparam int LAT_A = 2;
  localparam int QD_A  = 2;
  localparam int LAT_B = 4;
  localparam int QD_B  = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        wr = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        addr_ok_a, data_ok_a, addr_ok_b, data_ok_b;
  logic [31:0] rdata_a, rdata_b;

  int compared = 0;
  int mismatched = 0;

  sramlike_mem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT_A), .QUEUE_DEPTH(QD_A), .INIT_FILE("")) u_dut_a (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok_a), .data_ok(data_ok_a), .rdata(rdata_a)
  );

  sramlike_mem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT_B), .QUEUE_DEPTH(QD_B), .INIT_FILE("")) u_dut_b (
    .clk(clk), .rst(rst), .req(req), .wr(wr), .size(size), .addr(addr), .wdata(wdata),
    .addr_ok(addr_ok_b), .data_ok(data_ok_b), .rdata(rdata_b)
  );

  always #5 clk = ~clk;

  // Reference model: each accepted request records the edge on which it is due to retire.
  int          m_due   [2][16];
  logic        m_wr    [2][16];
  logic [1:0]  m_size  [2][16];
  logic [31:0] m_addr  [2][16];
  logic [31:0] m_wdata [2][16];
  int          m_head  [2];
  int          m_cnt   [2];
  logic [31:0] mref    [2][32];
  logic        exp_dok [2];
  logic        exp_dok_wr [2];
  logic [31:0] exp_rdata [2];
  bit          m_acc   [2];
  int          acc_tot [2];
  int          obs_dok [2];
  logic [15:0] lfsr;
  int          edge_n = 0;
  logic [31:0] last_rd;

  function automatic int lat_of(input int i);
    return (i == 0) ? LAT_A : LAT_B;
  endfunction

  function automatic int qd_of(input int i);
    return (i == 0) ? QD_A : QD_B;
  endfunction

  function automatic bit stall_ok();
`ifdef SRAMLIKE_RANDOM_STALL_EN
    return lfsr[1:0] != 2'b00;
`else
    return 1'b1;
`endif
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic mem_write(input int i, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] w;
    int b;
    w = mref[i][a[6:2]];
    b = int'(a[1:0]);
    case (s)
      2'd0: w[8*b +: 8] = d[8*b +: 8];
      2'd1: if (!a[0]) w[16*int'(a[1]) +: 16] = d[16*int'(a[1]) +: 16];
      default: if (a[1:0] == 2'b00) w = d;
    endcase
    mref[i][a[6:2]] = w;
  endtask

  task automatic model_edge(input int i);
    int ln, t;
    bit acc, pop;
    logic pw;
    logic [1:0] ps;
    logic [31:0] pa, pd;
    m_acc[i] = 1'b0;
    if (rst !== 1'b1) return;
    ln = lat_of(i);
    acc = req && (m_cnt[i] < qd_of(i)) && stall_ok();
    pop = 1'b0; pw = 1'b0; ps = 2'd0; pa = 32'h0; pd = 32'h0;
    if (m_cnt[i] > 0 && m_due[i][m_head[i]] == edge_n) begin
      pop = 1'b1;
      pw = m_wr[i][m_head[i]]; ps = m_size[i][m_head[i]];
      pa = m_addr[i][m_head[i]]; pd = m_wdata[i][m_head[i]];
      m_head[i] = (m_head[i] + 1) % 16;
      m_cnt[i]--;
    end else if (acc && ln == 1) begin
      pop = 1'b1; pw = wr; ps = size; pa = addr; pd = wdata;
    end
    if (acc && ln > 1) begin
      t = (m_head[i] + m_cnt[i]) % 16;
      m_due[i][t] = edge_n + ln - 1;
      m_wr[i][t] = wr; m_size[i][t] = size; m_addr[i][t] = addr; m_wdata[i][t] = wdata;
      m_cnt[i]++;
    end
    if (acc) begin
      m_acc[i] = 1'b1;
      acc_tot[i]++;
    end
    exp_dok[i] = pop;
    exp_dok_wr[i] = pw;
    if (pop) begin
      if (pw) begin
        mem_write(i, ps, pa, pd);
        exp_rdata[i] = 32'h0;
      end else begin
        exp_rdata[i] = mref[i][pa[6:2]];
      end
    end
  endtask

  task automatic check_inst(input int i, input logic aok, input logic dok, input logic [31:0] rd);
    logic exp_aok;
    exp_aok = rst && req && (m_cnt[i] < qd_of(i)) && stall_ok();
    check_output($sformatf("addr_ok[%0d]", i), {31'b0, aok}, {31'b0, exp_aok});
    check_output($sformatf("data_ok[%0d]", i), {31'b0, dok}, {31'b0, exp_dok[i]});
    check_output($sformatf("rdata[%0d]", i), rd, exp_rdata[i]);
    if (dok === 1'b1) obs_dok[i]++;
    if (i == 0 && exp_dok[0] && !exp_dok_wr[0]) last_rd = rd;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_inst(0, addr_ok_a, data_ok_a, rdata_a);
    check_inst(1, addr_ok_b, data_ok_b, rdata_b);
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    if (rst === 1'b1) lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    edge_n++;
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_head[i] = 0; m_acc[i] = 1'b0;
      exp_dok[i] = 1'b0; exp_dok_wr[i] = 1'b0; exp_rdata[i] = 32'h0;
    end
    lfsr = SEED;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    model_clear();
    cycle();
    rst = 1'b1;
  endtask

  // Holds the request until instance A takes it; B sees the same bus.
  task automatic apply_stimulus(input logic w, input logic [1:0] s, input logic [31:0] a, input logic [31:0] d);
    bit got;
    got = 1'b0;
    wr = w; size = s; addr = a; wdata = d; req = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      cycle();
      got = m_acc[0];
    end
    check_output($sformatf("accept@%h", a), 32'(got), 32'd1);
  endtask

  task automatic idle(input int n);
    req = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    req = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (m_cnt[0] == 0 && m_cnt[1] == 0) begin
        done = 1'b1;
        break;
      end
      cycle();
    end
    cycle();
    check_output("drain", 32'(done), 32'd1);
  endtask

  initial begin
    bit got;
    int n_acc;
    logic [31:0] r;

    acc_tot[0] = 0; acc_tot[1] = 0; obs_dok[0] = 0; obs_dok[1] = 0;
    last_rd = 32'h0;
    #1;
    req = 1'b1;
    pulse_reset();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    req = 1'b0;

    for (int w = 0; w < 32; w++) apply_stimulus(1'b1, 2'd2, 32'(w * 4), $urandom());
    apply_stimulus(1'b1, 2'd2, 32'h10, 32'h12345678);
    apply_stimulus(1'b1, 2'd2, 32'h20, 32'hFFFFFFFF);
    apply_stimulus(1'b1, 2'd2, 32'h44, 32'h11223344);
    apply_stimulus(1'b1, 2'd2, 32'h48, 32'hAAAAAAAA);
    drain();

    apply_stimulus(1'b0, 2'd2, 32'h10, 32'h0);
    drain();
    check_output("single_read", last_rd, 32'h12345678);

    apply_stimulus(1'b1, 2'd0, 32'h21, 32'h0000AB00);
    apply_stimulus(1'b0, 2'd2, 32'h20, 32'h0);
    drain();
    check_output("byte_merge", last_rd, 32'hFFFFABFF);

    apply_stimulus(1'b1, 2'd1, 32'h45, 32'h0000DEAD);
    apply_stimulus(1'b1, 2'd2, 32'h46, 32'hDEADBEEF);
    apply_stimulus(1'b0, 2'd2, 32'h44, 32'h0);
    drain();
    check_output("misaligned_ignored", last_rd, 32'h11223344);

    apply_stimulus(1'b1, 2'd1, 32'h4A, 32'hBEEF0000);
    apply_stimulus(1'b0, 2'd3, 32'h48, 32'h0);
    drain();
    check_output("halfword_upper", last_rd, 32'hBEEFAAAA);

    apply_stimulus(1'b1, 2'd2, 32'h1000_0050, 32'hCAFEF00D);
    apply_stimulus(1'b0, 2'd0, 32'hF000_0053, 32'h0);
    drain();
    check_output("addr_wrap", last_rd, 32'hCAFEF00D);

    for (int k = 0; k < 4; k++) apply_stimulus(1'b0, 2'd2, 32'(k * 4), 32'h0);
    drain();

    apply_stimulus(1'b0, 2'd2, 32'h0, 32'h0);
    apply_stimulus(1'b0, 2'd2, 32'h4, 32'h0);
    pulse_reset();
    idle(8);

    drain();
    obs_dok[0] = 0; obs_dok[1] = 0; acc_tot[0] = 0; acc_tot[1] = 0;
    got = 1'b1;
    n_acc = 0;
    for (int c = 0; c < 4000 && n_acc < 200; c++) begin
      if (!req || got) begin
        req = ($urandom_range(0, 3) != 0);
        wr = 1'($urandom_range(0, 1));
        size = 2'($urandom_range(0, 3));
        r = $urandom();
        addr = r & 32'hFFFF_F07F;
        wdata = $urandom();
      end
      cycle();
      got = m_acc[0];
      if (got) n_acc++;
    end
    check_output("random_accepts", 32'(n_acc), 32'd200);
    drain();
    check_output("dok_count[0]", 32'(obs_dok[0]), 32'(acc_tot[0]));
    check_output("dok_count[1]", 32'(obs_dok[1]), 32'(acc_tot[1]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
